uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART: independent transmitter (parallel byte to serial line) and receiver (serial line to parallel byte), sharing one clock and one reset.
- Sits between the on-chip byte interface and the board TX/RX pins.
- Baud rate is fixed at elaboration by a clocks-per-bit parameter.
- Loopback (serial_tx wired to serial_rx) must deliver every transmitted byte intact.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit period (12 MHz clock / 115200 baud); legal range >= 4.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- to_sent  in  8  byte to transmit, sampled when a flush is accepted
- flush  in  1  transmit request, level-sampled each clock
- busy  out  1  high while a TX frame is in progress
- serial_tx  out  1  TX line, idle high
- serial_rx  in  1  RX line, asynchronous to clk, idle high
- received  out  8  last correctly framed RX byte
- ready  out  1  one-cycle pulse when received is updated

Behaviour:
- Reset (async assert, while rst_n=0): serial_tx=1, busy=0, ready=0, received=8'h00; both FSMs go to IDLE and all counters clear.
- Reset mid-frame aborts the frame; serial_tx returns high immediately.
- Frame format: start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. No parity.
- TX FSM states: IDLE -> START -> DATA(bit index 0..7) -> STOP -> IDLE.
  - A flush is accepted on a rising edge where flush=1 and busy=0. That edge latches to_sent into a shift register, drives serial_tx=0 and sets busy=1.
  - serial_tx is registered and glitch-free.
  - busy stays high for exactly 10*CLKS_PER_BIT cycles. It falls on the edge that ends the stop bit, where the FSM re-enters IDLE with serial_tx=1.
  - flush while busy=1 is ignored and not queued. to_sent may change freely after acceptance.
  - flush held high continuously gives back-to-back frames with one idle cycle between stop and the next start.
- RX input: serial_rx passes through a 2-flop synchronizer; all RX logic uses the synchronized signal (2-cycle input latency).
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE, plus WAIT_HIGH.
  - IDLE: on a synchronized low, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2 (integer division), re-sample the line.
    - Still low: valid start; reset the counter and go to DATA.
    - High: glitch; go back to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) and shift in LSB first. After 8 samples go to STOP.
  - STOP: sample at mid-bit.
    - Sample is 1: load received with the assembled byte and pulse ready for exactly one cycle, aligned with the update. Return to IDLE immediately, so a new start can be caught in the second half of the stop bit.
    - Sample is 0 (framing error/break): no ready; received is unchanged. Go to WAIT_HIGH, which returns to IDLE once the line is high.
- received holds its value between frames. ready is never high for two consecutive cycles.
- TX and RX are fully independent; simultaneous activity on both is allowed.
- Counter width: $clog2(CLKS_PER_BIT)+1 bits; no wrap inside a bit period.

Test Plan:
- Loopback, CLKS_PER_BIT=104. Set to_sent=213 (8'hD5) and pulse flush for 1 cycle after 5 cycles of idle.
  - serial_tx shows 0,1,0,1,0,1,0,1,1,1, each bit held 104 cycles.
  - busy is high for 1040 cycles.
  - ready pulses once, with received=8'hD5.
- Back-to-back: pulse flush one cycle after each busy falling edge with 8'hD5. Three consecutive frames are each received as 8'hD5, giving exactly 3 ready pulses.
- Flush during busy: pulse flush with to_sent=8'h3C in the middle of an 8'hD5 frame. The frame is unaffected, no second frame follows, and received=8'hD5.
- RX glitch: drive serial_rx low for 20 cycles, then high. No ready pulse; received is unchanged.
- Framing error: drive a frame of 8'hA5 with the stop bit 0, then the line high. No ready and received keeps its prior value. A following valid 8'h5A frame yields ready with received=8'h5A.
- Reset mid-frame: assert rst_n=0 during data bit 3 of a TX frame. serial_tx=1, busy=0 and ready=0 immediately. After release, a new flush of 8'h81 transmits and is received correctly.

Source files
------------

// File: rtl/uart_transceiver_if.sv
// Byte-side and pin-side signal bundle for the 8N1 UART transceiver.
interface uart_transceiver_if;
  logic [7:0] to_sent;
  logic       flush;
  logic       busy;
  logic       serial_tx;
  logic       serial_rx;
  logic [7:0] received;
  logic       ready;

  // Master: byte client and RX line source
  modport master (
    output to_sent, flush, serial_rx,
    input  busy, serial_tx, received, ready
  );

  // Slave: the transceiver itself
  modport slave (
    input  to_sent, flush, serial_rx,
    output busy, serial_tx, received, ready
  );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with independent TX and RX state machines.
module uart_transceiver #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input logic             clk,
  input logic             rst_n,
  uart_transceiver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  logic [1:0]       tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_idx_q, tx_idx_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_busy_q, tx_busy_d;

  logic             rx_meta_q, rx_sync_q;
  logic [2:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_ready_q, rx_ready_d;

  // TX next-state: frame sequencing and line value for the next bit
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_busy_d  = tx_busy_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.flush) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_shift_d = bus.to_sent;
          tx_line_d  = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_idx_d  = tx_idx_q + 3'd1;
            tx_line_d = tx_shift_q[tx_idx_q + 3'd1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_line_d  = 1'b1;
          tx_busy_d  = 1'b0;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
        tx_line_d  = 1'b1;
        tx_busy_d  = 1'b0;
      end
    endcase
  end

  // TX state register; reset forces the line high at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // RX next-state: mid-bit sampling, glitch rejection, framing check
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_ready_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            rx_idx_d   = '0;
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_data_d  = rx_shift_q;
            rx_ready_d = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // RX synchronizer and state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_meta_q  <= bus.serial_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  assign bus.serial_tx = tx_line_q;
  assign bus.busy      = tx_busy_q;
  assign bus.received  = rx_data_q;
  assign bus.ready     = rx_ready_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed plus randomized bench for uart_transceiver with a frame-level model.
module tb_uart_transceiver;

  localparam int unsigned CLKS = 104;

  logic clk = 1'b0;
  logic rst_n;
  logic loop_en;
  logic rx_drv;

  always #5 clk = ~clk;

  uart_transceiver_if ifc ();

  assign ifc.serial_rx = loop_en ? ifc.serial_tx : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CLKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] rx_q[$];
  logic       prev_ready = 1'b0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect every ready pulse with the byte presented alongside it
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.ready === 1'b1) begin
      chk("ready_single_cycle", 32'(prev_ready), 32'd0);
      rx_q.push_back(ifc.received);
    end
    prev_ready <= ifc.ready;
  end

  // Transmit one byte, checking line and busy against the ideal frame every cycle.
  // Starts and ends just after a falling edge. abort_at>0 asserts reset at that cycle.
  task automatic run_frame(input logic [7:0] b, input bit mid_flush, input int abort_at);
    logic [9:0] frame;
    logic       exp_tx;
    logic       exp_busy;
    frame = {1'b1, b, 1'b0};
    chk("busy_before_flush", 32'(ifc.busy), 32'd0);
    ifc.to_sent = b;
    ifc.flush   = 1'b1;
    for (int n = 1; n <= int'(10 * CLKS) + 1; n++) begin
      @(negedge clk);
      exp_busy = (n <= int'(10 * CLKS));
      exp_tx   = exp_busy ? frame[(n - 1) / int'(CLKS)] : 1'b1;
      chk("tx_line", 32'(ifc.serial_tx), 32'(exp_tx));
      chk("tx_busy", 32'(ifc.busy), 32'(exp_busy));
      if (n == 1) ifc.flush = 1'b0;
      if (n == 2) ifc.to_sent = 8'($urandom);
      if (mid_flush && n == 500) begin
        ifc.to_sent = 8'h3C;
        ifc.flush   = 1'b1;
      end
      if (mid_flush && n == 501) ifc.flush = 1'b0;
      if (abort_at > 0 && n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_tx_high", 32'(ifc.serial_tx), 32'd1);
        chk("abort_busy_low", 32'(ifc.busy), 32'd0);
        chk("abort_ready_low", 32'(ifc.ready), 32'd0);
        chk("abort_received_clear", 32'(ifc.received), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  // Drive one 8N1 frame on the RX line from the bench
  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (CLKS) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // Wait (bounded) for the next received byte and compare it
  task automatic expect_rx(input logic [7:0] b);
    int waited;
    waited = 0;
    while (rx_q.size() == 0 && waited < int'(3 * CLKS)) begin
      @(negedge clk);
      waited++;
    end
    chk("rx_arrived", 32'(rx_q.size() != 0), 32'd1);
    if (rx_q.size() != 0) chk("rx_byte", 32'(rx_q.pop_front()), 32'(b));
    chk("received_value", 32'(ifc.received), 32'(b));
    last_good = b;
  endtask

  task automatic expect_none(input string tag);
    chk(tag, 32'(rx_q.size()), 32'd0);
    chk({tag, "_received_kept"}, 32'(ifc.received), 32'(last_good));
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] tb_byte;
    logic       stop_ok;

    rst_n       = 1'b0;
    loop_en     = 1'b1;
    rx_drv      = 1'b1;
    ifc.to_sent = 8'h00;
    ifc.flush   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(ifc.serial_tx), 32'd1);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_ready", 32'(ifc.ready), 32'd0);
    chk("rst_received", 32'(ifc.received), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback of 0xD5
    run_frame(8'hD5, 1'b0, 0);
    expect_rx(8'hD5);

    // Three back-to-back frames, one idle cycle apart
    run_frame(8'hD5, 1'b0, 0);
    run_frame(8'hD5, 1'b0, 0);
    run_frame(8'hD5, 1'b0, 0);
    repeat (4) @(negedge clk);
    chk("b2b_ready_count", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) expect_rx(8'hD5);

    // Flush while busy is ignored and not queued
    run_frame(8'hD5, 1'b1, 0);
    repeat (2 * CLKS) @(negedge clk);
    chk("no_queued_busy", 32'(ifc.busy), 32'd0);
    chk("no_queued_tx", 32'(ifc.serial_tx), 32'd1);
    expect_rx(8'hD5);
    expect_none("no_queued_rx");

    // Random loopback bytes with random idle gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      rb = 8'($urandom);
      run_frame(rb, 1'b0, 0);
      expect_rx(rb);
    end

    // Bench drives RX from here
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // Short low glitch is rejected
    rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    expect_none("glitch");

    // Framing error, then a valid frame
    drive_rx(8'hA5, 1'b0);
    repeat (2 * CLKS) @(negedge clk);
    expect_none("framing_error");
    drive_rx(8'h5A, 1'b1);
    expect_rx(8'h5A);

    // Random RX frames with occasional bad stop bit
    for (int i = 0; i < 5; i++) begin
      rb      = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      drive_rx(rb, stop_ok);
      if (stop_ok) begin
        expect_rx(rb);
      end else begin
        repeat (2 * CLKS) @(negedge clk);
        expect_none("rand_framing");
      end
      repeat (CLKS) @(negedge clk);
    end

    // Simultaneous TX and RX on independent lines
    tb_byte = 8'($urandom);
    rb      = 8'($urandom);
    fork
      run_frame(tb_byte, 1'b0, 0);
      drive_rx(rb, 1'b1);
    join
    expect_rx(rb);
    expect_none("duplex_single_rx");

    // Reset during data bit 3, then recovery
    loop_en = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(8'hC3, 1'b0, int'(4 * CLKS + CLKS / 2));
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    expect_none("after_abort");
    run_frame(8'h81, 1'b0, 0);
    expect_rx(8'h81);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
